// File: rtl/ysyx_041461_if_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_041461_if_ctrl -- instruction-fetch sequencer
//
// Controls the PC register and the instruction-memory port. For each PC value
// it issues one request (ireq_*), takes one response (irsp_*), and holds the
// instruction for ID (inst_*). It arbitrates redirects against sequential
// advance and drives the PC register's update strobe and source selects. A
// fetch that is in flight when a redirect arrives is dropped.
//
// Redirect priority: WB (MTVEC/MEPC) > ID (branch/jump) > sequential PC+4.
//
// Parameters
//   TIMEOUT_W    response-wait counter width; timeout after 2^TIMEOUT_W-1 cycles
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   redir_wb     WB redirect: 00 none, 01 MTVEC, 10 MEPC, 11 none
//   redir_id     ID redirect to the ID-computed next PC
//   ireq_valid   fetch request valid (address = current PC register value)
//   ireq_ready   memory accepts the request
//   irsp_valid   fetch response valid
//   irsp_inst    fetched instruction
//   irsp_ready   ready to take a response
//   inst_valid   instruction valid to ID
//   inst_out     held instruction
//   inst_ready   ID accepts the instruction
//   pc_enable    PC register update strobe, one cycle per update
//   pc_ctrl_id   PC select, ID path: 0 = PC+4, 1 = ID next PC
//   pc_ctrl_wb   PC select, WB path: same encoding as redir_wb
//   fetch_err    sticky response-timeout flag
//
// Optional feature (macro YSYX_041461_IFCTRL_PERF_EN)
//   perf_fetch   64-bit count of instructions handed to ID
//   perf_discard 64-bit count of dropped responses / held instructions
// ---------------------------------------------------------------------------
module ysyx_041461_if_ctrl #(
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  redir_wb,
  input  logic        redir_id,
  output logic        ireq_valid,
  input  logic        ireq_ready,
  input  logic        irsp_valid,
  input  logic [31:0] irsp_inst,
  output logic        irsp_ready,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  input  logic        inst_ready,
  output logic        pc_enable,
  output logic        pc_ctrl_id,
  output logic [1:0]  pc_ctrl_wb,
  output logic        fetch_err
`ifdef YSYX_041461_IFCTRL_PERF_EN
  ,
  output logic [63:0] perf_fetch,
  output logic [63:0] perf_discard
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  localparam logic [TIMEOUT_W-1:0] TMO_LIMIT = '1;
  localparam logic [TIMEOUT_W-1:0] TMO_NEAR  = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] TMO_ONE   = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;

  // Pending redirect, remembered while a fetch is in flight.
  logic                 pend_valid;
  logic [1:0]           pend_wb;
  logic                 pend_id;
  // Set when the fetch in flight belongs to a PC that a redirect superseded.
  logic                 discard_q;
  logic [TIMEOUT_W-1:0] tmo_cnt;

  // Control strobes from the FSM to the datapath registers.
  logic                 capture_redir;
  logic                 take_inst;
  logic                 drop;
  logic                 start_wait;
  logic                 in_wait;

  // Redirect decode for this cycle (WB beats ID).
  logic                 wb_now;
  logic                 redir_now;
  logic [1:0]           now_wb;
  logic                 now_id;
  logic [1:0]           upd_wb;
  logic                 upd_id;

  assign wb_now    = (redir_wb == 2'b01) || (redir_wb == 2'b10);
  assign redir_now = wb_now || redir_id;
  assign now_wb    = wb_now ? redir_wb : 2'b00;
  assign now_id    = !wb_now && redir_id;

  // Update source: redirect this cycle, else pending redirect, else PC+4.
  assign upd_wb = redir_now ? now_wb : (pend_valid ? pend_wb : 2'b00);
  assign upd_id = redir_now ? now_id : (pend_valid && pend_id);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    ireq_valid    = 1'b0;
    irsp_ready    = 1'b0;
    inst_valid    = 1'b0;
    pc_enable     = 1'b0;
    capture_redir = 1'b0;
    take_inst     = 1'b0;
    drop          = 1'b0;
    start_wait    = 1'b0;
    in_wait       = 1'b0;

    // Outputs stay quiet while reset is held, whatever the old state was.
    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          state_d   = S_REQ;
          pc_enable = redir_now;
        end

        S_REQ: begin
          ireq_valid    = 1'b1;
          capture_redir = redir_now;
          if (ireq_ready) begin
            state_d    = S_WAIT;
            start_wait = 1'b1;
          end
        end

        S_WAIT: begin
          irsp_ready = 1'b1;
          in_wait    = 1'b1;
          if (irsp_valid) begin
            if (discard_q || redir_now) begin
              drop      = 1'b1;
              pc_enable = 1'b1;
              state_d   = S_REQ;
            end else begin
              take_inst = 1'b1;
              state_d   = S_HOLD;
            end
          end else begin
            capture_redir = redir_now;
          end
        end

        S_HOLD: begin
          // A redirect retracts the offer in the same cycle, so ID never
          // consumes an instruction from the wrong path.
          inst_valid = !redir_now;
          if (redir_now) begin
            drop      = 1'b1;
            pc_enable = 1'b1;
            state_d   = S_REQ;
          end else if (inst_ready) begin
            pc_enable = 1'b1;
            state_d   = S_REQ;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign pc_ctrl_wb = pc_enable ? upd_wb : 2'b00;
  assign pc_ctrl_id = pc_enable && upd_id;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_wb    <= 2'b00;
      pend_id    <= 1'b0;
      discard_q  <= 1'b0;
      inst_out   <= 32'h0;
      tmo_cnt    <= '0;
      fetch_err  <= 1'b0;
    end else begin
      // Pending redirect: consumed by any update; a WB redirect replaces
      // anything, an ID redirect never displaces a pending WB redirect.
      if (pc_enable) begin
        pend_valid <= 1'b0;
        pend_wb    <= 2'b00;
        pend_id    <= 1'b0;
      end else if (capture_redir) begin
        if (wb_now) begin
          pend_valid <= 1'b1;
          pend_wb    <= redir_wb;
          pend_id    <= 1'b0;
        end else if (!(pend_valid && (pend_wb != 2'b00))) begin
          pend_valid <= 1'b1;
          pend_wb    <= 2'b00;
          pend_id    <= 1'b1;
        end
      end

      if (capture_redir) discard_q <= 1'b1;
      else if (drop)     discard_q <= 1'b0;

      if (take_inst) inst_out <= irsp_inst;

      // Wait counter saturates at its limit; the flag is raised on the edge
      // where the counter arrives there and is held until reset.
      if (start_wait) begin
        tmo_cnt <= '0;
      end else if (in_wait) begin
        if (tmo_cnt != TMO_LIMIT) tmo_cnt <= tmo_cnt + TMO_ONE;
        if (tmo_cnt == TMO_NEAR)  fetch_err <= 1'b1;
      end
    end
  end

`ifdef YSYX_041461_IFCTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch   <= 64'd0;
      perf_discard <= 64'd0;
    end else begin
      if (inst_valid && inst_ready) perf_fetch   <= perf_fetch + 64'd1;
      if (drop)                     perf_discard <= perf_discard + 64'd1;
    end
  end
`endif

endmodule
